// File: rtl/sms_timing_ring.sv
// sms_timing_ring: one-hot ring of binary triggers generating memory-cycle
// timing stages. Stage 0 is the rest stage; a cycle is STAGES edges long.
// Modes: IDLE, continuous RUN, single-cycle STEP, with graceful end-of-cycle
// stop and a completed-cycle counter.
// Optional ring-integrity check: define SMS_RING_CHECK_EN.
module sms_timing_ring #(
    parameter int unsigned STAGES = 6,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              step,
    input  logic              stop_req,
    output logic [STAGES-1:0] ring,
    output logic              busy,
    output logic              cycle_end,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_t;

    localparam logic [STAGES-1:0] RING_REST = {{(STAGES-1){1'b0}}, 1'b1};

    state_t             r_state;
    logic [STAGES-1:0]  r_ring;
    logic               r_cycle_end;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_stop_pend;

    state_t             w_state;
    logic [STAGES-1:0]  w_ring;
    logic               w_cycle_end;
    logic [CNT_W-1:0]   w_cnt;
    logic               w_stop_pend;
    logic [STAGES-1:0]  w_ring_rot;
    logic               w_at_wrap;

`ifdef SMS_RING_CHECK_EN
    logic               r_err;
    logic               w_err;
`endif

    assign w_ring_rot = {r_ring[STAGES-2:0], r_ring[STAGES-1]};
    assign w_at_wrap  = r_ring[STAGES-1];

    // Next-state: mode transitions, ring rotation, stop latch and cycle count
    always_comb begin
        w_state     = r_state;
        w_ring      = r_ring;
        w_cycle_end = 1'b0;
        w_cnt       = r_cnt;
        w_stop_pend = r_stop_pend;
`ifdef SMS_RING_CHECK_EN
        w_err       = r_err;
`endif
        case (r_state)
            IDLE: begin
                // run has priority over step; stop_req is not latched here
                if (run) begin
                    w_state = RUN;
                    w_ring  = w_ring_rot;
                end else if (step) begin
                    w_state = STEP;
                    w_ring  = w_ring_rot;
                end
            end
            default: begin
                // RUN or STEP: rotate every edge; step input is ignored
                w_ring = w_ring_rot;
                if (stop_req) begin
                    w_stop_pend = 1'b1;
                end
                if (w_at_wrap) begin
                    w_cycle_end = 1'b1;
                    w_cnt       = r_cnt + CNT_W'(1);
                    if (!(r_state == RUN && run && !r_stop_pend && !stop_req)) begin
                        w_state     = IDLE;
                        w_stop_pend = 1'b0;
                    end
                end
            end
        endcase
`ifdef SMS_RING_CHECK_EN
        // A corrupted ring aborts the cycle without counting it
        if (!$onehot(r_ring)) begin
            w_err       = 1'b1;
            w_ring      = RING_REST;
            w_state     = IDLE;
            w_stop_pend = 1'b0;
            w_cycle_end = 1'b0;
            w_cnt       = r_cnt;
        end
`endif
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ring      <= RING_REST;
            r_cycle_end <= 1'b0;
            r_cnt       <= '0;
            r_stop_pend <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_ring      <= w_ring;
            r_cycle_end <= w_cycle_end;
            r_cnt       <= w_cnt;
            r_stop_pend <= w_stop_pend;
        end
    end

`ifdef SMS_RING_CHECK_EN
    // Sticky integrity error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err;
        end
    end
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign ring      = r_ring;
    assign busy      = (r_state != IDLE);
    assign cycle_end = r_cycle_end;
    assign cycle_cnt = r_cnt;

endmodule

// File: tb/tb_sms_timing_ring.sv
// Directed testbench for sms_timing_ring: table of single-edge vectors plus
// hand-written multi-cycle sequences (graceful stop, continuous run, counter
// wrap with CNT_W=2, asynchronous mid-cycle reset, optional integrity check).
module tb_sms_timing_ring;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic        step;
    logic        stop_req;
    logic [5:0]  ring;
    logic        busy;
    logic        cycle_end;
    logic [15:0] cycle_cnt;
    logic        err;
    logic [5:0]  ring2;
    logic        busy2;
    logic        cycle_end2;
    logic [1:0]  cycle_cnt2;
    logic        err2;

    int unsigned n_checks;
    int unsigned n_fail;

    typedef struct {
        logic        run;
        logic        step;
        logic        stop_req;
        logic [5:0]  exp_ring;
        logic        exp_busy;
        logic        exp_cend;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    sms_timing_ring #(.STAGES(6), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .run(run), .step(step), .stop_req(stop_req),
        .ring(ring), .busy(busy), .cycle_end(cycle_end), .cycle_cnt(cycle_cnt), .err(err)
    );

    sms_timing_ring #(.STAGES(6), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .run(run), .step(step), .stop_req(stop_req),
        .ring(ring2), .busy(busy2), .cycle_end(cycle_end2), .cycle_cnt(cycle_cnt2), .err(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected normal completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic add(input logic r, input logic s, input logic q, input logic [5:0] er,
                       input logic eb, input logic ec, input logic [15:0] en);
        vec_t v;
        v.run = r; v.step = s; v.stop_req = q;
        v.exp_ring = er; v.exp_busy = eb; v.exp_cend = ec; v.exp_cnt = en;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; run = 1'b0; step = 1'b0; stop_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ring", 32'(ring), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_cend", 32'(cycle_end), 32'h0);
        chk("rst_cnt", 32'(cycle_cnt), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0; run = 1'b0; step = 1'b0; stop_req = 1'b0;

        // run pulse: one full cycle then IDLE
        add(1,0,0, 6'd2, 1,0,0);
        add(0,0,0, 6'd4, 1,0,0);
        add(0,0,0, 6'd8, 1,0,0);
        add(0,0,0, 6'd16,1,0,0);
        add(0,0,0, 6'd32,1,0,0);
        add(0,0,0, 6'd1, 0,1,1);
        add(0,0,0, 6'd1, 0,0,1);
        // step pulse, second step at stage 2 ignored
        add(0,1,0, 6'd2, 1,0,1);
        add(0,0,0, 6'd4, 1,0,1);
        add(0,1,0, 6'd8, 1,0,1);
        add(0,0,0, 6'd16,1,0,1);
        add(0,0,0, 6'd32,1,0,1);
        add(0,0,0, 6'd1, 0,1,2);
        // stop_req in IDLE must not be latched
        add(0,0,1, 6'd1, 0,0,2);
        add(1,0,0, 6'd2, 1,0,2);
        add(1,0,0, 6'd4, 1,0,2);
        add(1,0,0, 6'd8, 1,0,2);
        add(1,0,0, 6'd16,1,0,2);
        add(1,0,0, 6'd32,1,0,2);
        add(1,0,0, 6'd1, 1,1,3);
        add(1,0,0, 6'd2, 1,0,3);
        // run drops mid-cycle: cycle completes
        add(0,0,0, 6'd4, 1,0,3);
        add(0,0,0, 6'd8, 1,0,3);
        add(0,0,0, 6'd16,1,0,3);
        add(0,0,0, 6'd32,1,0,3);
        add(0,0,0, 6'd1, 0,1,4);
        add(0,0,0, 6'd1, 0,0,4);
        // held step: restart after wrap plus one idle clock
        add(0,1,0, 6'd2, 1,0,4);
        add(0,1,0, 6'd4, 1,0,4);
        add(0,1,0, 6'd8, 1,0,4);
        add(0,1,0, 6'd16,1,0,4);
        add(0,1,0, 6'd32,1,0,4);
        add(0,1,0, 6'd1, 0,1,5);
        add(0,1,0, 6'd2, 1,0,5);
        add(0,0,0, 6'd4, 1,0,5);
        add(0,0,0, 6'd8, 1,0,5);
        add(0,0,0, 6'd16,1,0,5);
        add(0,0,0, 6'd32,1,0,5);
        add(0,0,0, 6'd1, 0,1,6);
        add(0,0,0, 6'd1, 0,0,6);

        do_reset();
        foreach (vecs[i]) begin
            run = vecs[i].run; step = vecs[i].step; stop_req = vecs[i].stop_req;
            tick();
            chk($sformatf("vec%0d_ring", i), 32'(ring), 32'(vecs[i].exp_ring));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            chk($sformatf("vec%0d_cend", i), 32'(cycle_end), 32'(vecs[i].exp_cend));
            chk($sformatf("vec%0d_cnt", i), 32'(cycle_cnt), 32'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d_cnt2", i), 32'(cycle_cnt2), 32'(vecs[i].exp_cnt[1:0]));
            chk($sformatf("vec%0d_err", i), 32'(err), 32'h0);
        end

        // run held 3 cycles, stop_req at stage 3 of cycle 3
        do_reset();
        for (int e = 1; e <= 18; e++) begin
            run = 1'b1; step = 1'b0; stop_req = (e == 16);
            tick();
            chk($sformatf("stop_e%0d_ring", e), 32'(ring), 32'(1 << (e % 6)));
            chk($sformatf("stop_e%0d_busy", e), 32'(busy), 32'(e < 18));
            chk($sformatf("stop_e%0d_cend", e), 32'(cycle_end), 32'((e % 6) == 0));
            chk($sformatf("stop_e%0d_cnt", e), 32'(cycle_cnt), 32'(e / 6));
        end
        run = 1'b0; stop_req = 1'b0;
        tick();
        chk("stop_after_ring", 32'(ring), 32'h1);
        chk("stop_after_busy", 32'(busy), 32'h0);
        chk("stop_after_cend", 32'(cycle_end), 32'h0);
        chk("stop_after_cnt", 32'(cycle_cnt), 32'd3);

        // run and step together with run held: continuous RUN
        do_reset();
        for (int e = 1; e <= 24; e++) begin
            run = (e <= 18); step = (e == 1); stop_req = 1'b0;
            tick();
            chk($sformatf("cont_e%0d_ring", e), 32'(ring), 32'(1 << (e % 6)));
            chk($sformatf("cont_e%0d_busy", e), 32'(busy), 32'(e < 24));
            chk($sformatf("cont_e%0d_cend", e), 32'(cycle_end), 32'((e % 6) == 0));
            chk($sformatf("cont_e%0d_cnt", e), 32'(cycle_cnt), 32'(e / 6));
            chk($sformatf("cont_e%0d_cnt2", e), 32'(cycle_cnt2), 32'((e / 6) % 4));
        end

        // CNT_W=2 over 5 cycles (1,2,3,0,1), then async reset at stage 4
        do_reset();
        for (int e = 1; e <= 34; e++) begin
            run = 1'b1; step = 1'b0; stop_req = 1'b0;
            tick();
            if ((e % 6) == 0) begin
                chk($sformatf("wrap2_e%0d_cnt2", e), 32'(cycle_cnt2), 32'((e / 6) % 4));
                chk($sformatf("wrap2_e%0d_cend2", e), 32'(cycle_end2), 32'h1);
            end
        end
        chk("pre_rst_ring", 32'(ring), 32'd16);
        chk("pre_rst_busy", 32'(busy), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_ring", 32'(ring), 32'h1);
        chk("async_rst_busy", 32'(busy), 32'h0);
        chk("async_rst_cnt", 32'(cycle_cnt), 32'h0);
        chk("async_rst_cend", 32'(cycle_end), 32'h0);
        chk("async_rst_ring2", 32'(ring2), 32'h1);
        chk("async_rst_busy2", 32'(busy2), 32'h0);
        chk("async_rst_cnt2", 32'(cycle_cnt2), 32'h0);
        run = 1'b0;
        @(negedge clk);

`ifdef SMS_RING_CHECK_EN
        // forced double bit during RUN -> sticky err, ring back to rest
        do_reset();
        run = 1'b1;
        tick();
        tick();
        run = 1'b0;
        force u_dut.r_ring = 6'b000110;
        tick();
        release u_dut.r_ring;
        tick();
        chk("chk_err", 32'(err), 32'h1);
        chk("chk_ring", 32'(ring), 32'h1);
        chk("chk_busy", 32'(busy), 32'h0);
        chk("chk_cnt", 32'(cycle_cnt), 32'h0);
        tick();
        tick();
        chk("chk_err_sticky", 32'(err), 32'h1);
        chk("chk_ring_hold", 32'(ring), 32'h1);
`else
        do_reset();
        run = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
        end
        chk("nochk_err", 32'(err), 32'h0);
        chk("nochk_err2", 32'(err2), 32'h0);
        run = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
